// File: rtl/ram512_mover_pkg.sv
// ram512_mover_pkg
//   Shared constants and the FSM state type for ram512_block_mover.
//   ADDR_W : RAM address width (512 words)
//   DATA_W : RAM word width
//   LEN_W  : transfer length width; one bit wider than ADDR_W so that a
//            full-RAM transfer (512 words) is representable.
package ram512_mover_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } mover_state_t;

endpackage

// File: rtl/ram512_block_mover.sv
// ram512_block_mover
//   Bus master that copies a block of words inside a ram512, one word at a
//   time (read cycle, then write cycle), ascending, with address wrap
//   modulo 512. Optional fill mode writes a constant pattern instead.
//
//   Optional feature macro: RAM512_BLOCK_MOVER_FILL_EN
//     defined   -> fill_mode / fill_value ports exist, fill skips RD
//     undefined -> copy only
//
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start           : request pulse, honoured only in IDLE
//   src_addr        : first source word address
//   dst_addr        : first destination word address
//   len             : word count 0..512
//   busy            : high while a transfer is in progress (through DONE)
//   done            : one-cycle completion pulse
//   mem_address     : to RAM address
//   mem_value       : to RAM value
//   mem_load        : to RAM load (write at rising edge while high)
//   mem_out         : from RAM out (combinational read of mem_address)
//   fill_mode       : (macro only) fill instead of copy
//   fill_value      : (macro only) fill pattern
module ram512_block_mover
  import ram512_mover_pkg::*;
#(
  parameter int ADDR_W = ram512_mover_pkg::ADDR_W,
  parameter int DATA_W = ram512_mover_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_value,
  output logic              mem_load,
`ifdef RAM512_BLOCK_MOVER_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
`endif
  input  logic [DATA_W-1:0] mem_out
);

  mover_state_t state_q, state_d;

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   i_q, i_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef RAM512_BLOCK_MOVER_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fval_q, fval_d;
`endif

  // Bus outputs are registered: they are computed from the *next* state and
  // next counter value, so the bus is valid for the whole cycle the FSM
  // spends in RD/WR and mem_load can be cleared by the async reset.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    data_d  = data_q;
`ifdef RAM512_BLOCK_MOVER_FILL_EN
    fill_d  = fill_q;
    fval_d  = fval_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          len_d = len;
          i_d   = '0;
`ifdef RAM512_BLOCK_MOVER_FILL_EN
          fill_d = fill_mode;
          fval_d = fill_value;
          if (len == '0)     state_d = DONE;
          else if (fill_mode) state_d = WR;
          else               state_d = RD;
`else
          if (len == '0) state_d = DONE;
          else           state_d = RD;
`endif
        end
      end
      RD: begin
        data_d  = mem_out;
        state_d = WR;
      end
      WR: begin
        i_d = i_q + (ADDR_W+1)'(1);
        if (i_d == len_q) state_d = DONE;
`ifdef RAM512_BLOCK_MOVER_FILL_EN
        else if (fill_q)  state_d = WR;
`endif
        else              state_d = RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_d  = '0;
    value_d = '0;
    load_d  = 1'b0;
    case (state_d)
      RD: addr_d = src_d + i_d[ADDR_W-1:0];
      WR: begin
        addr_d = dst_d + i_d[ADDR_W-1:0];
`ifdef RAM512_BLOCK_MOVER_FILL_EN
        value_d = fill_d ? fval_d : data_d;
`else
        value_d = data_d;
`endif
        load_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      value_q <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef RAM512_BLOCK_MOVER_FILL_EN
      fill_q  <= 1'b0;
      fval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef RAM512_BLOCK_MOVER_FILL_EN
      fill_q  <= fill_d;
      fval_q  <= fval_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_value   = value_q;
  assign mem_load    = load_q;

endmodule

// File: tb/tb_ram512_block_mover.sv
// Self-checking bench for ram512_block_mover with a 512x16 RAM responder.
module tb_ram512_block_mover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  src_addr, dst_addr;
  logic [9:0]  len;
  logic        busy, done;
  logic [8:0]  mem_address;
  logic [15:0] mem_value, mem_out;
  logic        mem_load;
  logic        fill_mode;
  logic [15:0] fill_value;

  // RAM responder plus a preload port driven by the bench
  logic [15:0] ram [512];
  logic        pre_we;
  logic [8:0]  pre_a;
  logic [15:0] pre_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram512_block_mover dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_value  (mem_value),
    .mem_load   (mem_load),
`ifdef RAM512_BLOCK_MOVER_FILL_EN
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
`endif
    .mem_out    (mem_out)
  );

  assign mem_out = ram[mem_address];

  always @(posedge clk) begin
    if (pre_we)        ram[pre_a] <= pre_d;
    else if (mem_load) ram[mem_address] <= mem_value;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (owned by this process) ----------------
  logic [15:0] mref [512];
  logic [15:0] tmp  [512];
  int          wa   [512];
  logic [15:0] wd   [512];
  int          m_src, m_len, cnt, lat, k;
  bit          active = 0, m_fill, exp_load, exp_busy, exp_done, is_rd, fm_eff;
  bit          pend_v = 0;
  int          pend_a;
  logic [15:0] pend_d;

  initial forever begin
    @(posedge clk);
    if (pend_v && rst_n) mref[pend_a] = pend_d;
    pend_v = 0;
    if (pre_we) mref[pre_a] = pre_d;
    if (!rst_n) begin
      active = 0;
    end else if (start && (!active || cnt > lat)) begin
`ifdef RAM512_BLOCK_MOVER_FILL_EN
      fm_eff = fill_mode;
`else
      fm_eff = 0;
`endif
      m_src  = int'(src_addr);
      m_len  = int'(len);
      m_fill = fm_eff;
      lat    = (m_len == 0) ? 1 : (m_fill ? m_len + 1 : 2 * m_len + 1);
      for (int j = 0; j < 512; j++) tmp[j] = mref[j];
      // ascending word-at-a-time: earlier writes are visible to later reads
      for (int j = 0; j < m_len; j++) begin
        wa[j] = (int'(dst_addr) + j) % 512;
        wd[j] = m_fill ? fill_value : tmp[(m_src + j) % 512];
        tmp[wa[j]] = wd[j];
      end
      active = 1;
      cnt    = 1;
    end else if (active) begin
      cnt++;
    end

    #1;
    if (!rst_n) begin
      chk("rst_busy",  {31'b0, busy}, 0);
      chk("rst_done",  {31'b0, done}, 0);
      chk("rst_load",  {31'b0, mem_load}, 0);
      chk("rst_addr",  {23'b0, mem_address}, 0);
      chk("rst_value", {16'b0, mem_value}, 0);
    end else begin
      exp_busy = active && cnt <= lat;
      exp_done = active && cnt == lat;
      exp_load = 0;
      is_rd    = 0;
      k        = 0;
      if (active && cnt < lat) begin
        if (m_fill)            begin exp_load = 1; k = cnt - 1; end
        else if (cnt % 2 == 0) begin exp_load = 1; k = cnt / 2 - 1; end
        else                   begin is_rd = 1;    k = (cnt - 1) / 2; end
      end
      chk("busy",     {31'b0, busy}, {31'b0, exp_busy});
      chk("done",     {31'b0, done}, {31'b0, exp_done});
      chk("mem_load", {31'b0, mem_load}, {31'b0, exp_load});
      if (exp_load) begin
        chk("wr_addr", {23'b0, mem_address}, 32'(wa[k]));
        chk("wr_data", {16'b0, mem_value}, {16'b0, wd[k]});
        pend_v = 1;
        pend_a = wa[k];
        pend_d = wd[k];
      end
      if (is_rd) chk("rd_addr", {23'b0, mem_address}, 32'((m_src + k) % 512));
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input int a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1; pre_a = 9'(a); pre_d = d;
    @(negedge clk);
    pre_we = 0;
  endtask

  // Returns the cycle (1 = cycle after acceptance edge) in which done was seen.
  // Returns while still in the done cycle so the next call is back-to-back.
  task automatic xfer(input int s, input int d, input int l, input bit fm,
                      input logic [15:0] fv, input bit poke, output int dcyc);
    int n;
    @(negedge clk);
    src_addr = 9'(s); dst_addr = 9'(d); len = 10'(l);
    fill_mode = fm; fill_value = fv; start = 1;
    @(negedge clk);
    n = 1;
    while (!done && n < 1100) begin
      src_addr = 9'($urandom); dst_addr = 9'($urandom); len = 10'($urandom);
      fill_mode = 1'($urandom); fill_value = 16'($urandom);
      start = poke && (n == 2);
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("done_seen", {31'b0, done}, 1);
    dcyc = n;
  endtask

  initial begin
    int dc, mism, l;
    logic [15:0] s6;
    bit fm;
    rst_n = 0; start = 0; src_addr = '0; dst_addr = '0; len = '0;
    fill_mode = 0; fill_value = '0; pre_we = 0; pre_a = '0; pre_d = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;

    for (int j = 0; j < 512; j++) begin
      @(negedge clk);
      pre_we = 1; pre_a = 9'(j); pre_d = 16'($urandom);
    end
    @(negedge clk);
    pre_we = 0;

    // basic two-word copy
    preload(131, 16'h0003);
    preload(132, 16'h000F);
    xfer(131, 109, 2, 0, 16'h0, 0, dc);
    chk("basic_lat", dc, 5);
    chk("basic_w0", {16'b0, ram[109]}, 32'h0003);
    chk("basic_w1", {16'b0, ram[110]}, 32'h000F);

    // zero length
    s6 = ram[6];
    xfer(5, 6, 0, 0, 16'h0, 0, dc);
    chk("len0_lat", dc, 1);
    chk("len0_ram", {16'b0, ram[6]}, {16'b0, s6});

    // forward overlap through the wrap point
    preload(510, 16'h1111);
    preload(511, 16'h2222);
    preload(0,   16'h3333);
    preload(1,   16'h4444);
    xfer(510, 0, 4, 0, 16'h0, 0, dc);
    chk("wrap_lat", dc, 9);
    chk("wrap_0", {16'b0, ram[0]}, 32'h1111);
    chk("wrap_1", {16'b0, ram[1]}, 32'h2222);
    chk("wrap_2", {16'b0, ram[2]}, 32'h1111);
    chk("wrap_3", {16'b0, ram[3]}, 32'h2222);

    // reset during the write of word 3 of an 8-word copy
    @(negedge clk);
    src_addr = 9'd20; dst_addr = 9'd200; len = 10'd8; fill_mode = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    chk("pre_rst_load", {31'b0, mem_load}, 1);
    rst_n = 0;
    #1;
    chk("async_load", {31'b0, mem_load}, 0);
    chk("async_busy", {31'b0, busy}, 0);
    chk("async_done", {31'b0, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    xfer(20, 200, 8, 0, 16'h0, 0, dc);
    chk("restart_lat", dc, 17);

    // start while busy with other arguments is ignored
    xfer(40, 60, 6, 0, 16'h0, 1, dc);
    chk("poke_lat", dc, 13);

`ifdef RAM512_BLOCK_MOVER_FILL_EN
    xfer(0, 300, 3, 1, 16'hA5A5, 0, dc);
    chk("fill_lat", dc, 4);
    chk("fill_0", {16'b0, ram[300]}, 32'hA5A5);
    chk("fill_1", {16'b0, ram[301]}, 32'hA5A5);
    chk("fill_2", {16'b0, ram[302]}, 32'hA5A5);
`endif

    // full-RAM copy
    xfer(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 512, 0, 16'h0, 0, dc);
    chk("full_lat", dc, 1025);

    // randomized back-to-back transfers
    for (int j = 0; j < 25; j++) begin
      l  = int'($urandom_range(0, 24));
`ifdef RAM512_BLOCK_MOVER_FILL_EN
      fm = 1'($urandom);
`else
      fm = 0;
`endif
      xfer(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), l, fm,
           16'($urandom), (l >= 2) && ($urandom_range(0, 1) == 1), dc);
    end

    repeat (2) @(negedge clk);
    mism = 0;
    for (int j = 0; j < 512; j++) if (ram[j] !== mref[j]) mism++;
    chk("ram_final_mismatches", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
